button_conditioner: RTL and testbench

//  Conditions raw active-low board pushbuttons and slide switches before they reach slc3 (Run, Continue, S).
//  Per button: 2-FF synchronise, debounce, then emit one-cycle press/release pulses and a clean level.

---
 rtl/btn_pkg.sv | 19 +
 rtl/debounce_channel.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 58 +++++
 tb/tb_button_conditioner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton conditioner.
// Latency: n/a (package only).
// Backpressure: n/a; no handshake anywhere in this block.
package btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [2:0] {
    ARM    = 3'd0,
    UP     = 3'd1,
    DOWN_P = 3'd2,
    DOWN   = 3'd3,
    UP_P   = 3'd4
  } btn_state_t;

  // 10 ms at 50 MHz for the board; short value for simulation.
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int DEBOUNCE_SIM     = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF sync, debounce FSM, registered level and press/release pulses.
// Latency: raw edge to pulse is 2 + DEBOUNCE_CYCLES + 1 cycles for a clean edge.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
//
// Ports:
//   Clk, Reset  clock and asynchronous active-low reset
//   btn_n_i     raw active-low button, asynchronous to Clk
//   level_o     debounced level, 1 = held
//   press_o     one-cycle pulse when a press is accepted
//   release_o   one-cycle pulse when a release is accepted
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       r_sync;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic             w_s;
  logic [CNT_W-1:0] w_cnt_inc;

  // Synchronised, active-high view of the button.
  assign w_s = ~r_sync[1];
  // Saturating increment so the counter can never wrap.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      // Sync flops reset to "released" so a held button is seen only after reset.
      r_sync    <= 2'b11;
      r_state   <= ARM;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], btn_n_i};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        // Requires a full debounce window of "released" before arming, so a
        // button held through reset cannot produce a spurious press.
        ARM: begin
          if (w_s) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= UP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        UP: begin
          if (w_s) begin
            r_state <= DOWN_P;
            r_cnt   <= '0;
          end
        end
        DOWN_P: begin
          if (!w_s) begin
            r_state <= UP;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= DOWN;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DOWN: begin
          if (!w_s) begin
            r_state <= UP_P;
            r_cnt   <= '0;
          end
        end
        UP_P: begin
          if (w_s) begin
            r_state <= DOWN;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= UP;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ARM;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign level_o   = r_level;
  assign press_o   = r_press;
  assign release_o = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw active-low buttons (debounce + pulses) and synchronises the switch bus.
// Latency: buttons 2 + DEBOUNCE_CYCLES + 1 cycles; switches 2 cycles.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
//
// Ports:
//   Clk, Reset  clock and asynchronous active-low reset
//   btn_n_i     raw active-low buttons (bit0 = Run, bit1 = Continue)
//   sw_i        raw slide switches
//   level_o     debounced button levels, 1 = held
//   press_o     one-cycle press pulses
//   release_o   one-cycle release pulses
//   sw_o        synchronised switches
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_BTN-1:0]  btn_n_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic [NUM_BTN-1:0]  level_o,
  output logic [NUM_BTN-1:0]  press_o,
  output logic [NUM_BTN-1:0]  release_o,
  output logic [SW_WIDTH-1:0] sw_o
);

  logic [SW_WIDTH-1:0] r_sw_meta;
  logic [SW_WIDTH-1:0] r_sw_sync;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign sw_o = r_sw_sync;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .Clk      (Clk),
      .Reset    (Reset),
      .btn_n_i  (btn_n_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a short debounce window.
// Latency: expected pulses are queued with the cycle they must appear in.
// Backpressure: n/a.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int NB = 2;
  localparam int SW = 16;
  localparam int LAT = 2 + DEBOUNCE_SIM + 1;

  logic          Clk;
  logic          Reset;
  logic [NB-1:0] btn_n_i;
  logic [SW-1:0] sw_i;
  logic [NB-1:0] level_o;
  logic [NB-1:0] press_o;
  logic [NB-1:0] release_o;
  logic [SW-1:0] sw_o;

  button_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DEBOUNCE_SIM),
    .SW_WIDTH(SW)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .btn_n_i  (btn_n_i),
    .sw_i     (sw_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .sw_o     (sw_o)
  );

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] level;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic expect_ev(input int at, input logic [NB-1:0] p, input logic [NB-1:0] r,
                           input logic [NB-1:0] l);
    ev_t e;
    e.cyc = at;
    e.press = p;
    e.rel = r;
    e.level = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed pulse must match the head of the expectation queue.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && (press_o !== '0 || release_o !== '0)) begin
      check("pulse_exclusive", 32'(press_o & release_o), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {16'(press_o), 16'(release_o)}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("press_o", 32'(press_o), 32'(e.press));
        check("release_o", 32'(release_o), 32'(e.rel));
        check("level_at_pulse", 32'(level_o), 32'(e.level));
      end
    end
  end

  initial begin
    if (cyc < 0) $display("unreachable");
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    Reset   = 1'b0;
    btn_n_i = 2'b11;
    sw_i    = '0;

    // Reset state
    wait_cyc(3);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_press", 32'(press_o), 32'd0);
    check("rst_release", 32'(release_o), 32'd0);
    check("rst_sw", 32'(sw_o), 32'd0);
    Reset = 1'b1;
    wait_cyc(10);
    check("idle_level", 32'(level_o), 32'd0);

    // Clean press and release on bit0
    t = cyc;
    btn_n_i[0] = 1'b0;
    expect_ev(t + LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(20);
    check("held_level", 32'(level_o), 32'h1);
    t = cyc;
    btn_n_i[0] = 1'b1;
    expect_ev(t + LAT, 2'b00, 2'b01, 2'b00);
    wait_cyc(12);

    // Bounce on bit1: low2 high1 low2 high1, then held low
    btn_n_i[1] = 1'b0; wait_cyc(2);
    btn_n_i[1] = 1'b1; wait_cyc(1);
    btn_n_i[1] = 1'b0; wait_cyc(2);
    btn_n_i[1] = 1'b1; wait_cyc(1);
    t = cyc;
    btn_n_i[1] = 1'b0;
    expect_ev(t + LAT, 2'b10, 2'b00, 2'b10);
    wait_cyc(5);
    check("bounce_level", 32'(level_o), 32'd0);
    wait_cyc(10);
    t = cyc;
    btn_n_i[1] = 1'b1;
    expect_ev(t + LAT, 2'b00, 2'b10, 2'b00);
    wait_cyc(12);

    // Both channels together
    t = cyc;
    btn_n_i = 2'b00;
    expect_ev(t + LAT, 2'b11, 2'b00, 2'b11);
    wait_cyc(12);
    t = cyc;
    btn_n_i = 2'b11;
    expect_ev(t + LAT, 2'b00, 2'b11, 2'b00);
    wait_cyc(12);

    // Button held through reset deassert: no press until released and re-pressed
    btn_n_i[0] = 1'b0;
    Reset = 1'b0;
    wait_cyc(3);
    Reset = 1'b1;
    wait_cyc(30);
    check("held_rst_level", 32'(level_o), 32'd0);
    btn_n_i[0] = 1'b1;
    wait_cyc(20);
    t = cyc;
    btn_n_i[0] = 1'b0;
    expect_ev(t + LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(12);
    t = cyc;
    btn_n_i[0] = 1'b1;
    expect_ev(t + LAT, 2'b00, 2'b01, 2'b00);
    wait_cyc(20);

    // Reset two cycles into DOWN_P discards the pending press
    btn_n_i[0] = 1'b0;
    wait_cyc(5);
    Reset = 1'b0;
    btn_n_i[0] = 1'b1;
    #1;
    check("midrst_level", 32'(level_o), 32'd0);
    check("midrst_press", 32'(press_o), 32'd0);
    wait_cyc(3);
    Reset = 1'b1;
    wait_cyc(15);
    check("post_midrst_level", 32'(level_o), 32'd0);

    // Switch synchroniser: two edges of latency
    sw_i = 16'hA5C3;
    wait_cyc(1);
    check("sw_1edge", 32'(sw_o), 32'h0);
    wait_cyc(1);
    check("sw_2edge", 32'(sw_o), 32'hA5C3);
    sw_i = 16'h5A3C;
    wait_cyc(1);
    check("sw_hold", 32'(sw_o), 32'hA5C3);
    wait_cyc(1);
    check("sw_next", 32'(sw_o), 32'h5A3C);

    wait_cyc(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
